// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Combinational 1-bit full-adder cell, reusable by any bit-serial datapath.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit pair per clock, LSB first,
// through a single full-adder cell with a registered carry.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_psum;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic             w_load;
  logic [WIDTH-1:0] w_psum_next;

  full_adder u_full_adder (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_c)
  );

  assign w_last = (r_cnt == LAST_BIT);
  // A new operation is only accepted when not shifting; DONE allows back-to-back.
  assign w_load = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_psum_next = {w_s, {(WIDTH-1){1'b0}}} | (r_psum >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = IDLE;
    case (r_state)
      IDLE:    w_state_next = start ? SHIFT : IDLE;
      SHIFT:   w_state_next = w_last ? DONE : SHIFT;
      DONE:    w_state_next = start ? SHIFT : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B on load and seed the carry with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_a     <= A;
      r_b     <= Sub ? ~B : B;
      r_psum  <= '0;
      r_carry <= Sub ? 1'b1 : Cin;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_psum  <= w_psum_next;
      r_carry <= w_c;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_psum_next;
        r_cout <= w_c;
      end
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;

endmodule
